// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the Hamming SECDED stream encoder.
// Holds the injection-mode enum, the FSM state enums and the position-map helpers.
package hamming_pkg;

  typedef enum logic [1:0] {
    INJ_NONE     = 2'b00,
    INJ_SINGLE   = 2'b01,
    INJ_DOUBLE   = 2'b10,
    INJ_NONE_ALT = 2'b11
  } inj_mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b10
  } occ_e;

  typedef enum logic {
    INJ_IDLE  = 1'b0,
    INJ_ARMED = 1'b1
  } inj_state_e;

  // Smallest m with 2**m >= m + k + 1.
  function automatic int calculate_m(input int k);
    int m;
    m = 1;
    while ((2 ** m) < (m + k + 1)) m++;
    return m;
  endfunction

  // Hamming position (1-based) of information bit idx; skips power-of-two slots.
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    while (cnt < idx) begin
      pos++;
      if ((pos & (pos - 1)) != 0) cnt++;
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_secded_core.sv
// Combinational SECDED encoder: q[N:1] is the Hamming codeword, q[0] the overall parity.
module hamming_secded_core
  import hamming_pkg::*;
#(
  parameter  int K = 8,
  localparam int M = calculate_m(K),
  localparam int N = M + K
) (
  input  logic [K-1:0] d,
  output logic [N:0]   q
);

  logic [N:1] data_map;
  logic [N:1] ham;

  genvar g;
  for (g = 0; g < K; g++) begin : g_data
    assign data_map[data_pos(g)] = d[g];
  end
  for (g = 0; g < M; g++) begin : g_pslot
    assign data_map[2 ** g] = 1'b0;
  end

  // Parity slots start at zero in data_map, so XOR-ing over covered positions is exact.
  always_comb begin
    ham = data_map;
    for (int j = 0; j < M; j++) begin
      for (int p = 1; p <= N; p++) begin
        if (((p >> j) & 1) == 1) ham[2 ** j] = ham[2 ** j] ^ data_map[p];
      end
    end
  end

  assign q = {ham, ^ham};

endmodule

// File: rtl/hamming_secded_enc_stream.sv
// Streaming SECDED encoder with a two-entry output buffer (output + skid register),
// registered input ready, armable error injection and an output word counter.
module hamming_secded_enc_stream
  import hamming_pkg::*;
#(
  parameter  int K     = 8,
  parameter  int CNT_W = 16,
  localparam int M     = calculate_m(K),
  localparam int N     = M + K,
  localparam int PW    = $clog2(N + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [K-1:0]     d_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [N:0]       q_o,
  output logic [M:1]       p_o,
  output logic             p0_o,
  input  logic             inj_arm_i,
  input  logic [1:0]       inj_mode_i,
  input  logic [PW-1:0]    inj_pos_i,
  input  logic [PW-1:0]    inj_pos2_i,
  output logic             inj_armed_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  // Handshake: a word moves on s_* when s_valid_i && s_ready_o, and on m_* when
  // m_valid_o && m_ready_i; valid never waits on ready, ready is a register.

  logic [N:0]       enc_word;
  logic [N:0]       inj_mask;
  logic [N:0]       cw_in;
  logic [N:0]       out_q;
  logic [N:0]       skid_q;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             xfer;
  logic             load_out;
  logic             load_skid;
  logic             out_from_skid;

  occ_e             occ;
  occ_e             occ_nxt;
  inj_state_e       inj_state;
  inj_state_e       inj_state_nxt;
  inj_mode_e        inj_mode_q;
  logic [PW-1:0]    inj_pos_q;
  logic [PW-1:0]    inj_pos2_q;

  hamming_secded_core #(.K(K)) u_core (
    .d (d_i),
    .q (enc_word)
  );

  assign accept = s_valid_i && ready_q;
  assign xfer   = (occ != OCC_EMPTY) && m_ready_i;

  // Positions above N never match an index, so they flip nothing; equal
  // positions in double mode toggle twice and cancel.
  always_comb begin
    inj_mask = '0;
    if (inj_state == INJ_ARMED) begin
      for (int i = 0; i <= N; i++) begin
        if ((inj_mode_q == INJ_SINGLE || inj_mode_q == INJ_DOUBLE) && inj_pos_q == PW'(i))
          inj_mask[i] = ~inj_mask[i];
        if (inj_mode_q == INJ_DOUBLE && inj_pos2_q == PW'(i))
          inj_mask[i] = ~inj_mask[i];
      end
    end
  end

  assign cw_in = enc_word ^ inj_mask;

  always_comb begin
    inj_state_nxt = inj_state;
    if (inj_arm_i) inj_state_nxt = INJ_ARMED;
    else if (accept) inj_state_nxt = INJ_IDLE;
  end

  always_comb begin
    occ_nxt       = occ;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (occ)
      OCC_EMPTY: begin
        if (accept) begin
          occ_nxt  = OCC_ONE;
          load_out = 1'b1;
        end
      end
      OCC_ONE: begin
        if (accept && xfer) begin
          load_out = 1'b1;
        end else if (accept) begin
          occ_nxt   = OCC_TWO;
          load_skid = 1'b1;
        end else if (xfer) begin
          occ_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (xfer) begin
          occ_nxt       = OCC_ONE;
          out_from_skid = 1'b1;
        end
      end
      default: occ_nxt = OCC_EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ       <= OCC_EMPTY;
      ready_q   <= 1'b1;
      inj_state <= INJ_IDLE;
    end else begin
      occ       <= occ_nxt;
      ready_q   <= (occ_nxt != OCC_TWO);
      inj_state <= inj_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q      <= '0;
      skid_q     <= '0;
      cnt_q      <= '0;
      inj_mode_q <= INJ_NONE;
      inj_pos_q  <= '0;
      inj_pos2_q <= '0;
    end else begin
      if (load_out) out_q <= cw_in;
      else if (out_from_skid) out_q <= skid_q;
      if (load_skid) skid_q <= cw_in;
      if (xfer) cnt_q <= cnt_q + 1'b1;
      if (inj_arm_i) begin
        inj_mode_q <= inj_mode_e'(inj_mode_i);
        inj_pos_q  <= inj_pos_i;
        inj_pos2_q <= inj_pos2_i;
      end
    end
  end

  always_comb begin
    p_o = '0;
    for (int i = 1; i <= M; i++) p_o[i] = out_q[2 ** (i - 1)];
  end

  assign m_valid_o   = (occ != OCC_EMPTY);
  assign s_ready_o   = ready_q;
  assign q_o         = out_q;
  assign p0_o        = out_q[0];
  assign inj_armed_o = (inj_state == INJ_ARMED);
  assign word_cnt_o  = cnt_q;

endmodule
